sd_spi: RTL and testbench

- APB-slave SPI master that lets the CPU talk to an SD card in SPI mode, one byte at a time.
- Software writes a byte over APB and the block shifts it out on MOSI while shifting a byte in from MISO. Software then polls status and reads the received byte.
- Sits between the APB bus and the SD card pins (or the sd_sim card model in simulation).

---
 rtl/sd_spi.sv | 184 ++++++++++++++++++
 tb/tb_sd_spi.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi.sv
// sd_spi: APB-slave SPI master for talking to an SD card in SPI mode.
// Software writes a byte to DATA, the block shifts it out MSB first on
// mosi (mode 0) while capturing a byte from miso, then software polls
// STATUS and reads the received byte back from DATA.
module sd_spi #(
  parameter logic [7:0] DIV_RESET = 8'h7C
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic [7:0] paddr,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  localparam logic [7:0] A_DATA   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h01;
  localparam logic [7:0] A_CTRL   = 8'h02;
  localparam logic [7:0] A_CLKDIV = 8'h03;

  // Software-visible registers
  logic [7:0] r_rxdata;
  logic       r_rxv;
  logic       r_err;
  logic       r_cs_assert;
  logic       r_en;
  logic [7:0] r_clkdiv;

  // Transfer engine state
  logic [1:0] r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bitcnt;
  logic [7:0] r_cnt;
  logic [7:0] r_div;      // CLKDIV snapshot taken at transfer start
  logic       r_sclk;
  logic       r_mosi;
  logic       r_cs;

  logic w_wr;
  logic w_rd_data;
  logic w_busy;
  logic w_start;
  logic w_collide;
  logic w_done;

  assign w_wr      = psel & penable & pwrite;
  assign w_rd_data = psel & penable & ~pwrite & (paddr == A_DATA);
  assign w_busy    = (r_state != S_IDLE);
  assign w_start   = w_wr & (paddr == A_DATA) & r_en & ~w_busy;
  assign w_collide = w_wr & (paddr == A_DATA) & w_busy;
  // Final falling SCLK edge of the eighth bit
  assign w_done    = (r_state == S_HIGH) & (r_cnt == 8'd0) & (r_bitcnt == 3'd7);

  assign pready = 1'b1;
  assign sclk   = r_sclk;
  assign mosi   = r_mosi;
  assign cs     = r_cs;

  // CTRL / CLKDIV writes and the sticky collision flag
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_cs_assert <= 1'b0;
      r_en        <= 1'b0;
      r_clkdiv    <= DIV_RESET;
      r_err       <= 1'b0;
    end else begin
      if (w_wr && paddr == A_CTRL) begin
        r_cs_assert <= pwdata[0];
        r_en        <= pwdata[1];
      end
      if (w_wr && paddr == A_CLKDIV) begin
        r_clkdiv <= pwdata;
      end
      if (w_collide) begin
        r_err <= 1'b1;
      end else if (w_wr && paddr == A_STATUS && pwdata[2]) begin
        r_err <= 1'b0;
      end
    end
  end

  // RXV: set on completion, cleared by a DATA read; a same-cycle set wins
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_rxv <= 1'b0;
    end else if (w_done) begin
      r_rxv <= 1'b1;
    end else if (w_rd_data) begin
      r_rxv <= 1'b0;
    end
  end

  // Transfer FSM: half-period countdown, shift on rising edge, drive on falling edge
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state  <= S_IDLE;
      r_shift  <= 8'h00;
      r_bitcnt <= 3'd0;
      r_cnt    <= 8'h00;
      r_div    <= 8'h00;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b1;
      r_rxdata <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_LOW;
            r_shift  <= pwdata;
            r_mosi   <= pwdata[7];
            r_bitcnt <= 3'd0;
            r_cnt    <= r_clkdiv;
            r_div    <= r_clkdiv;
          end
        end
        S_LOW: begin
          if (r_cnt == 8'd0) begin
            r_sclk  <= 1'b1;
            r_shift <= {r_shift[6:0], miso};
            r_cnt   <= r_div;
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_HIGH: begin
          if (r_cnt == 8'd0) begin
            r_sclk <= 1'b0;
            if (r_bitcnt == 3'd7) begin
              r_rxdata <= r_shift;
              r_mosi   <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
              r_mosi   <= r_shift[7];
              r_cnt    <= r_div;
              r_state  <= S_LOW;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Chip select follows CTRL.CS_ASSERT only while no transfer is in progress
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_cs <= 1'b1;
    end else if (r_state == S_IDLE) begin
      r_cs <= ~r_cs_assert;
    end
  end

  // Combinational APB read mux
  always_comb begin
    prdata = 8'h00;
    if (psel && !pwrite) begin
      case (paddr)
        A_DATA:   prdata = r_rxdata;
        A_STATUS: prdata = {5'b0, r_err, r_rxv, w_busy};
        A_CTRL:   prdata = {6'b0, r_en, r_cs_assert};
        A_CLKDIV: prdata = r_clkdiv;
        default:  prdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi.sv
// tb_sd_spi: directed and randomized checks of sd_spi against a simple
// byte-level model of an SPI mode-0 exchange.
module tb_sd_spi;
  logic       pclk = 1'b0;
  logic       preset;
  logic [7:0] paddr;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;

  int total = 0;
  int bad   = 0;

  sd_spi dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1 d = prdata;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] want);
    logic [7:0] d;
    apb_read(a, d);
    chk(tag, {24'h0, d}, {24'h0, want});
    $display("read  addr=%0h data=%02h want=%02h", a, d, want);
  endtask

  // Runs one transfer: starts it with a DATA write, plays the card side on
  // miso, polls STATUS.BUSY every cycle, records mosi at each rising SCLK.
  // An optional APB write is injected at busy cycle hook_at.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] rxpat, input int div,
                      input int hook_at, input logic [7:0] hook_addr, input logic [7:0] hook_data,
                      input int abort_at,
                      output logic [7:0] got_mosi, output int busy_len, output int rises,
                      output bit period_ok, output bit cs_low_ok);
    int last;
    logic prev_sclk;
    logic bsy;
    int limit;
    limit = 16 * (div + 1) + 20;
    last = -1;
    prev_sclk = 1'b0;
    got_mosi = 8'h00;
    busy_len = 0;
    rises = 0;
    period_ok = 1'b1;
    cs_low_ok = 1'b1;
    miso = rxpat[7];
    apb_write(8'h00, tx);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 8'h01;
    for (int cyc = 0; cyc < limit; cyc++) begin
      #1;
      bsy = pwrite ? 1'b1 : prdata[0];
      if (bsy !== 1'b1) break;
      busy_len++;
      if (cs !== 1'b0) cs_low_ok = 1'b0;
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (last >= 0 && (cyc - last) != 2 * (div + 1)) period_ok = 1'b0;
        last = cyc;
        got_mosi = {got_mosi[6:0], mosi};
        rises++;
        if (rises < 8) miso = rxpat[7 - rises];
        if (abort_at > 0 && rises == abort_at) begin
          psel = 1'b0;
          return;
        end
      end
      prev_sclk = sclk;
      @(negedge pclk);
      if (hook_at >= 0 && cyc + 1 == hook_at) begin
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = hook_addr; pwdata = hook_data;
      end else if (hook_at >= 0 && cyc + 1 == hook_at + 1) begin
        penable = 1'b1;
      end else begin
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 8'h01;
      end
    end
    psel = 1'b0; pwrite = 1'b0; penable = 1'b0;
    $display("xfer  tx=%02h mosi=%02h busy=%0d rises=%0d", tx, got_mosi, busy_len, rises);
  endtask

  initial begin
    logic [7:0] gm;
    int bl;
    int rs;
    bit pok;
    bit csok;
    logic [7:0] tx;
    logic [7:0] rx;
    int dv;
    bit sclk_seen;

    preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; miso = 1'b1;
    repeat (3) @(negedge pclk);
    chk("rst_cs", {31'h0, cs}, 32'h1);
    chk("rst_sclk", {31'h0, sclk}, 32'h0);
    chk("rst_mosi", {31'h0, mosi}, 32'h1);
    chk("rst_prdata", {24'h0, prdata}, 32'h0);
    chk("rst_pready", {31'h0, pready}, 32'h1);
    preset = 1'b1;
    rd_chk("rst_data", 8'h00, 8'h00);
    rd_chk("rst_status", 8'h01, 8'h00);
    rd_chk("rst_ctrl", 8'h02, 8'h00);
    rd_chk("rst_clkdiv", 8'h03, 8'h7C);

    // Basic transfer
    apb_write(8'h03, 8'h01);
    apb_write(8'h02, 8'h03);
    chk("cs_before_reg", {31'h0, cs}, 32'h1);
    @(negedge pclk);
    chk("cs_after_reg", {31'h0, cs}, 32'h0);
    xfer(8'hA5, 8'h3C, 1, -1, 8'h00, 8'h00, 0, gm, bl, rs, pok, csok);
    chk("basic_mosi", {24'h0, gm}, 32'hA5);
    chk("basic_busy", bl, 32);
    chk("basic_rises", rs, 8);
    chk("basic_period", {31'h0, pok}, 32'h1);
    chk("basic_idle_mosi", {31'h0, mosi}, 32'h1);
    rd_chk("basic_status", 8'h01, 8'h02);
    rd_chk("basic_data", 8'h00, 8'h3C);
    rd_chk("basic_status2", 8'h01, 8'h00);

    // Busy collision
    xfer(8'hFF, 8'h81, 1, 5, 8'h00, 8'h11, 0, gm, bl, rs, pok, csok);
    chk("coll_mosi", {24'h0, gm}, 32'hFF);
    chk("coll_busy", bl, 32);
    rd_chk("coll_status", 8'h01, 8'h06);
    apb_write(8'h01, 8'h04);
    rd_chk("coll_clr", 8'h01, 8'h02);
    rd_chk("coll_data", 8'h00, 8'h81);
    rd_chk("coll_status2", 8'h01, 8'h00);

    // Enable off
    apb_write(8'h02, 8'h01);
    apb_write(8'h00, 8'h55);
    sclk_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (sclk !== 1'b0) sclk_seen = 1'b1;
    end
    chk("en_off_sclk", {31'h0, sclk_seen}, 32'h0);
    rd_chk("en_off_status", 8'h01, 8'h00);

    // Fastest clock, CTRL rewrite mid-transfer
    apb_write(8'h03, 8'h00);
    apb_write(8'h02, 8'h03);
    @(negedge pclk);
    xfer(8'h00, 8'h96, 0, 4, 8'h02, 8'h02, 0, gm, bl, rs, pok, csok);
    chk("fast_mosi", {24'h0, gm}, 32'h00);
    chk("fast_busy", bl, 16);
    chk("fast_period", {31'h0, pok}, 32'h1);
    chk("fast_cs_low", {31'h0, csok}, 32'h1);
    chk("fast_cs_hold", {31'h0, cs}, 32'h0);
    @(negedge pclk);
    chk("fast_cs_rise", {31'h0, cs}, 32'h1);
    rd_chk("fast_data", 8'h00, 8'h96);

    // Randomized transfers checked against the byte-exchange model
    apb_write(8'h02, 8'h03);
    for (int n = 0; n < 6; n++) begin
      tx = 8'($urandom_range(0, 255));
      rx = 8'($urandom_range(0, 255));
      dv = int'($urandom_range(0, 3));
      apb_write(8'h03, 8'(dv));
      xfer(tx, rx, dv, -1, 8'h00, 8'h00, 0, gm, bl, rs, pok, csok);
      chk("rand_mosi", {24'h0, gm}, {24'h0, tx});
      chk("rand_busy", bl, 16 * (dv + 1));
      chk("rand_period", {31'h0, pok}, 32'h1);
      rd_chk("rand_status", 8'h01, 8'h02);
      rd_chk("rand_data", 8'h00, rx);
    end

    // Reset mid-transfer
    apb_write(8'h03, 8'h01);
    xfer(8'hC3, 8'h5A, 1, -1, 8'h00, 8'h00, 4, gm, bl, rs, pok, csok);
    chk("abort_rises", rs, 4);
    #2 preset = 1'b0;
    #1;
    chk("abort_cs", {31'h0, cs}, 32'h1);
    chk("abort_sclk", {31'h0, sclk}, 32'h0);
    chk("abort_mosi", {31'h0, mosi}, 32'h1);
    @(negedge pclk);
    preset = 1'b1;
    rd_chk("abort_data", 8'h00, 8'h00);
    rd_chk("abort_status", 8'h01, 8'h00);
    rd_chk("abort_clkdiv", 8'h03, 8'h7C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
